// File: rtl/mem_stream_readout_pkg.sv
// Shared definitions for the memory stream readout blocks: idle tag, FSM
// encoding and the port priority encoder.
package mem_stream_readout_pkg;

  localparam int MAX_TAG_W = 16;
  // Truncate to the tag width in use; the all-ones tag never names a real port.
  localparam logic [MAX_TAG_W-1:0] IDLE_TAG_ALL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_stream_readout_if.sv
// Bus between the readout block, its paged memories and the stream consumer.
interface mem_stream_readout_if #(
  parameter int NPORTS = 12,
  parameter int DW     = 44,
  parameter int AW     = 6,
  parameter int NW     = 7,
  parameter int SELW   = 4,
  parameter int BXW    = 3
);
  logic                   start;
  logic [BXW-1:0]         BX;
  logic [NPORTS*NW-1:0]   nent;
  logic [NPORTS-1:0]      rd_en;
  logic [BXW+AW-1:0]      rd_addr;
  logic [NPORTS*DW-1:0]   mem_dat;
  logic [SELW+DW-1:0]     stream_out;
  logic                   stream_valid;
  logic                   done;
  logic                   truncated;

  modport master (
    output start, BX, nent, mem_dat,
    input  rd_en, rd_addr, stream_out, stream_valid, done, truncated
  );

  modport slave (
    input  start, BX, nent, mem_dat,
    output rd_en, rd_addr, stream_out, stream_valid, done, truncated
  );
endinterface

// File: rtl/mem_stream_readout_tag_delay.sv
// RD_LAT-deep {valid, tag} shift register that lines port tags up with
// returning memory data; clr drops everything in flight.
module mem_tag_delay #(
  parameter int DEPTH = 2,
  parameter int TW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [TW-1:0] in_tag,
  output logic          out_vld,
  output logic [TW-1:0] out_tag
);

  logic [DEPTH-1:0] vld_p;
  logic [TW-1:0]    tag_p [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
  end

  assign out_vld = vld_p[DEPTH-1];
  assign out_tag = tag_p[DEPTH-1];

endmodule

// File: rtl/mem_stream_readout.sv
// Per-BX readout: walks non-empty memories in port order, one read per
// cycle, and streams tagged words out with a read budget and done flag.
module mem_stream_readout
  import mem_stream_readout_pkg::*;
#(
  parameter int NPORTS = 12,
  parameter int DW     = 44,
  parameter int AW     = 6,
  parameter int NW     = 7,
  parameter int SELW   = 4,
  parameter int BXW    = 3,
  parameter int RD_LAT = 2,
  parameter int TMAX   = 108
) (
  input logic clk,
  input logic reset,
  mem_stream_readout_if.slave bus
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [SELW-1:0] IDLE_TAG = IDLE_TAG_ALL[SELW-1:0];

  rd_state_t         state;
  logic [NPORTS-1:0] mask;
  logic [AW-1:0]     addr;
  logic [CW-1:0]     rdcnt;
  logic [2:0]        dcnt;
  logic [BXW-1:0]    bx_q;
  logic [NW-1:0]     nent_q   [NPORTS];
  logic [NW-1:0]     nent_new [NPORTS];
  logic [DW-1:0]     mem_w    [NPORTS];
  logic [NPORTS-1:0] mask_new;
  logic [NPORTS-1:0] p_onehot;
  logic [PW-1:0]     cur_p;
  logic              last_of_port;

  logic [NPORTS-1:0]   rd_en_p0;
  logic [BXW+AW-1:0]   rd_addr_p0;
  logic [SELW-1:0]     rd_tag_p0;
  logic                done_q;
  logic                trunc_q;
  logic                head_vld;
  logic [SELW-1:0]     head_tag;
  logic [SELW+DW-1:0]  stream_out_p1;
  logic                stream_vld_p1;

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      nent_new[i] = bus.nent[i*NW +: NW];
      mask_new[i] = (nent_new[i] != '0);
      mem_w[i]    = bus.mem_dat[i*DW +: DW];
    end
  end

  always_comb begin
    cur_p           = PW'(lowest_set(16'(mask)));
    p_onehot        = '0;
    p_onehot[cur_p] = 1'b1;
    last_of_port    = (({1'b0, addr} + NW'(1)) == nent_q[cur_p]);
  end

  always_ff @(posedge clk) begin
    if (bus.start && !reset) begin
      bx_q   <= bus.BX;
      nent_q <= nent_new;
    end
  end

  // Stage p0: read issue (registered rd_en/rd_addr plus the tag that follows them)
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '0;
      addr       <= '0;
      rdcnt      <= '0;
      dcnt       <= '0;
      rd_en_p0   <= '0;
      rd_addr_p0 <= '0;
      rd_tag_p0  <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else if (bus.start) begin
      mask     <= mask_new;
      addr     <= '0;
      rdcnt    <= '0;
      dcnt     <= '0;
      rd_en_p0 <= '0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
      state    <= (mask_new != '0) ? READ : DRAIN;
    end else begin
      case (state)
        IDLE: rd_en_p0 <= '0;
        READ: begin
          rd_en_p0   <= p_onehot;
          rd_addr_p0 <= {bx_q, addr};
          rd_tag_p0  <= SELW'(cur_p);
          rdcnt      <= rdcnt + CW'(1);
          dcnt       <= '0;
          if (last_of_port) begin
            mask <= mask & ~p_onehot;
            addr <= '0;
          end else begin
            addr <= addr + AW'(1);
          end
          // An exact fit of the budget finishes normally, not truncated.
          if (last_of_port && ((mask & ~p_onehot) == '0)) begin
            state <= DRAIN;
          end else if (rdcnt == CW'(TMAX - 1)) begin
            trunc_q <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          rd_en_p0 <= '0;
          if (dcnt == 3'(RD_LAT)) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: begin
          rd_en_p0 <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  mem_tag_delay #(
    .DEPTH (RD_LAT),
    .TW    (SELW)
  ) u_tag_delay (
    .clk     (clk),
    .clr     (reset | bus.start),
    .in_vld  (|rd_en_p0),
    .in_tag  (rd_tag_p0),
    .out_vld (head_vld),
    .out_tag (head_tag)
  );

  // Stage p1: output register, memory data joined to its tag
  always_ff @(posedge clk) begin
    if (reset) begin
      stream_out_p1 <= {IDLE_TAG, {DW{1'b0}}};
      stream_vld_p1 <= 1'b0;
    end else if (head_vld) begin
      stream_out_p1 <= {head_tag, mem_w[head_tag]};
      stream_vld_p1 <= 1'b1;
    end else begin
      stream_out_p1 <= {IDLE_TAG, {DW{1'b0}}};
      stream_vld_p1 <= 1'b0;
    end
  end

  assign bus.rd_en        = rd_en_p0;
  assign bus.rd_addr      = rd_addr_p0;
  assign bus.stream_out   = stream_out_p1;
  assign bus.stream_valid = stream_vld_p1;
  assign bus.done         = done_q;
  assign bus.truncated    = trunc_q;

endmodule

// File: tb/tb_mem_stream_readout.sv
// Bench for mem_stream_readout: table of BX vectors plus restart and reset
// sequences, checked against a scoreboard filled from a reference walk.
module tb_mem_stream_readout;

  localparam int DW     = 44;
  localparam int RD_LAT = 2;
  localparam int TMAX   = 108;
  localparam logic [47:0] IDLE_WORD = 48'hF00000000000;

  typedef struct {
    logic [11:0] en;
    logic [8:0]  addr;
  } rd_exp_t;

  typedef struct {
    logic [2:0]  bx;
    logic [83:0] nv;
    int          reads;
    logic        trunc;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   rd_seen;
  int   ignore_until;
  logic mon_en;

  rd_exp_t     rdq [$];
  logic [47:0] stq [$];
  int          lat_q [$];
  rd_exp_t     mon_re;
  vec_t        vt [7];
  logic [8:0]  a_d [RD_LAT];

  mem_stream_readout_if bus ();

  mem_stream_readout dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input int port, input logic [8:0] a);
    logic [22:0] mix;
    mix = 23'(port * 977 + int'(a) * 13);
    return {4'hD, 8'(port), a, mix};
  endfunction

  // Memory model: data for the address issued RD_LAT cycles earlier.
  always @(posedge clk) begin
    a_d[0] <= bus.rd_addr;
    for (int i = 1; i < RD_LAT; i++) a_d[i] <= a_d[i-1];
  end

  always_comb begin
    bus.mem_dat = '0;
    for (int i = 0; i < 12; i++) bus.mem_dat[i*DW +: DW] = mem_word(i, a_d[RD_LAT-1]);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [83:0] np(input int p, input int v);
    logic [83:0] r;
    r = '0;
    r[p*7 +: 7] = 7'(v);
    return r;
  endfunction

  function automatic logic [83:0] all_n(input int v);
    logic [83:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[i*7 +: 7] = 7'(v);
    return r;
  endfunction

  task automatic clear_sb();
    rdq.delete();
    stq.delete();
    lat_q.delete();
    rd_seen = 0;
  endtask

  // Reference walk: ascending port, ascending address, capped at TMAX.
  task automatic push_bx(input logic [2:0] bx, input logic [83:0] nv);
    int      cnt;
    int      n;
    rd_exp_t e;
    cnt = 0;
    clear_sb();
    for (int i = 0; i < 12; i++) begin
      n = int'(nv[i*7 +: 7]);
      for (int a = 0; a < n; a++) begin
        if (cnt < TMAX) begin
          e.en   = 12'(1) << i;
          e.addr = {bx, 6'(a)};
          rdq.push_back(e);
          stq.push_back({4'(i), mem_word(i, e.addr)});
          cnt++;
        end
      end
    end
  endtask

  task automatic do_start(input logic [2:0] bx, input logic [83:0] nv);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.BX    = bx;
    bus.nent  = nv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    push_bx(bx, nv);
    ignore_until = cyc + RD_LAT + 1;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && bus.done !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    check("done_wait", 64'(bus.done), 64'(1));
  endtask

  task automatic run_vec(input vec_t t);
    do_start(t.bx, t.nv);
    @(negedge clk);
    check("done_clr", 64'(bus.done), 64'(0));
    wait_done(400);
    check("reads", 64'(rd_seen), 64'(t.reads));
    check("truncated", 64'(bus.truncated), 64'(t.trunc));
    check("rdq_left", 64'(rdq.size()), 64'(0));
    check("stq_left", 64'(stq.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_en != '0) begin
        rd_seen++;
        if (rdq.size() == 0) begin
          check("rd_extra", 64'(bus.rd_en), 64'(0));
        end else begin
          mon_re = rdq.pop_front();
          check("rd_en", 64'(bus.rd_en), 64'(mon_re.en));
          check("rd_addr", 64'(bus.rd_addr), 64'(mon_re.addr));
          lat_q.push_back(cyc);
        end
      end
      if (cyc >= ignore_until) begin
        if (bus.stream_valid) begin
          if (stq.size() == 0) begin
            check("stream_extra", 64'(bus.stream_out), 64'(IDLE_WORD));
          end else begin
            check("stream_out", 64'(bus.stream_out), 64'(stq.pop_front()));
            check("done_last", 64'(bus.done), 64'(stq.size() == 0));
            if (lat_q.size() > 0) check("stream_lat", 64'(cyc - lat_q.pop_front()), 64'(RD_LAT + 1));
          end
        end else begin
          check("idle_word", 64'(bus.stream_out), 64'(IDLE_WORD));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0; rd_seen = 0; ignore_until = 0; mon_en = 1'b0;
    reset = 1'b1; bus.start = 1'b0; bus.BX = '0; bus.nent = '0;

    vt[0] = '{bx: 3'd3, nv: np(0, 2) | np(5, 1),   reads: 3,   trunc: 1'b0};
    vt[1] = '{bx: 3'd5, nv: '0,                    reads: 0,   trunc: 1'b0};
    vt[2] = '{bx: 3'd1, nv: all_n(10),             reads: 108, trunc: 1'b1};
    vt[3] = '{bx: 3'd7, nv: np(3, 64),             reads: 64,  trunc: 1'b0};
    vt[4] = '{bx: 3'd2, nv: np(0, 44) | np(11, 64), reads: 108, trunc: 1'b0};
    vt[5] = '{bx: 3'd0, nv: np(1, 1) | np(7, 3) | np(11, 5), reads: 9, trunc: 1'b0};
    vt[6] = '{bx: 3'd6, nv: np(0, 64) | np(1, 45), reads: 108, trunc: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 64'(bus.rd_en), 64'(0));
    check("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
    check("rst_stream_out", 64'(bus.stream_out), 64'(IDLE_WORD));
    check("rst_stream_valid", 64'(bus.stream_valid), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_truncated", 64'(bus.truncated), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vt[v]);

    // Empty BX: done exactly three clocks after the start edge
    do_start(3'd4, '0);
    repeat (3) @(negedge clk);
    check("empty_done_early", 64'(bus.done), 64'(0));
    @(negedge clk);
    check("empty_done", 64'(bus.done), 64'(1));
    check("empty_valid", 64'(bus.stream_valid), 64'(0));
    repeat (2) @(negedge clk);

    // Restart while port 2 is being read
    do_start(3'd2, np(0, 3) | np(2, 20));
    for (int i = 0; i < 100 && bus.rd_en !== 12'h004; i++) @(negedge clk);
    check("restart_reach", 64'(bus.rd_en), 64'(12'h004));
    repeat (2) @(negedge clk);
    do_start(3'd4, np(1, 2) | np(6, 3));
    @(negedge clk);
    check("restart_done_clr", 64'(bus.done), 64'(0));
    wait_done(200);
    check("restart_reads", 64'(rd_seen), 64'(5));
    check("restart_rdq", 64'(rdq.size()), 64'(0));
    check("restart_stq", 64'(stq.size()), 64'(0));
    repeat (2) @(negedge clk);

    // Reset mid-stream, with a start pulse that reset must override
    do_start(3'd1, all_n(10));
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    clear_sb();
    @(negedge clk);
    check("mid_rst_stream", 64'(bus.stream_out), 64'(IDLE_WORD));
    check("mid_rst_valid", 64'(bus.stream_valid), 64'(0));
    check("mid_rst_rd_en", 64'(bus.rd_en), 64'(0));
    check("mid_rst_done", 64'(bus.done), 64'(0));
    check("mid_rst_trunc", 64'(bus.truncated), 64'(0));
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_reads", 64'(rd_seen), 64'(0));

    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stream_readout.md
Name: mem_stream_readout

Overview:
- Parametrised successor to the fixed 12-port memory stream mux.
- Once per bunch crossing (BX), it walks all non-empty input memories in priority order and issues one read per cycle. It tags each returned word with its port index and streams the words out on one registered bus.
- Sits between the per-BX paged stub memories and the serial link/stream formatter.
- New relative to the fixed mux: the block generates the read addresses itself, compensates for read latency, skips empty ports, truncates at a per-BX read budget, and reports completion.

Parameters:
- NPORTS, 12, number of input memories; must satisfy NPORTS <= 2**SELW - 1.
- DW, 44, data width per memory word.
- AW, 6, address width within one BX page.
- NW, 7, width of the entry counts (AW+1, so a count of 2**AW is legal).
- SELW, 4, width of the port tag in the output word.
- BXW, 3, width of the BX page field.
- RD_LAT, 2, memory read latency in clocks (1..4).
- TMAX, 108, maximum number of reads issued per BX (truncation budget).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse marking a new BX.
- BX  in  BXW  BX whose page is to be read; sampled on start.
- nent  in  NPORTS*NW  flat per-port entry counts; port i occupies [i*NW +: NW]; sampled on start.
- rd_en  out  NPORTS  one-hot read enable.
- rd_addr  out  BXW+AW  shared read address, formed as {BX_latched, addr}.
- mem_dat  in  NPORTS*DW  flat read data; port i occupies [i*DW +: DW].
- stream_out  out  SELW+DW  output word {tag, data}.
- stream_valid  out  1  stream_out carries real data.
- done  out  1  high from the last data word until the next start.
- truncated  out  1  the current BX hit the TMAX budget.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, stream_out={all-ones, 0}, stream_valid=0, done=0, truncated=0. FSM goes to IDLE and all delay-line valid bits are cleared.
- FSM states: IDLE, READ, DRAIN.
- start in any state, including mid-READ and mid-DRAIN:
  - latch BX and nent;
  - build mask[i] = (nent_i != 0);
  - clear rdcnt, done, truncated and all delay-line valids; words still in flight from the previous BX are dropped;
  - go to READ if the mask is non-zero, else DRAIN.
- READ, every cycle:
  - p = lowest set bit of mask (priority encoder);
  - rd_en = onehot(p), rd_addr = {BX_latched, addr};
  - addr++ and rdcnt++.
  - When addr == nent_p - 1, clear mask[p] and reset addr to 0. The next port is read on the following cycle; there is no bubble between ports.
  - When the mask becomes empty, go to DRAIN.
  - If rdcnt reaches TMAX before the mask is empty: set truncated=1 and go to DRAIN. No further reads are issued.
- rd_en and rd_addr are registered outputs, so a read appears 1 clock after the FSM decision.
- Tag delay line: RD_LAT stages of {valid, p}, aligned with mem_dat.
- Output register:
  - delay-line head valid: stream_out <= {p_d, mem_dat[p_d]}, stream_valid <= 1;
  - otherwise: stream_out <= {all-ones tag, 0}, stream_valid <= 0.
  - The all-ones tag is reserved as the idle marker.
- Latency from rd_en asserted to the matching stream_out is RD_LAT+1 clocks.
- DRAIN: count RD_LAT+1 cycles so the final word reaches stream_out, then set done=1 and go to IDLE.
  - An empty BX still raises done, RD_LAT+1 cycles after the start pulse.
- A start coinciding with reset is ignored; reset wins.
- Stream words are ordered by ascending port, then ascending address.

Decomposition:
- Shared package: idle-tag constant (all ones, SELW bits), FSM state encoding, and a priority-encoder function returning the lowest set index.
- One sub-module, mem_tag_delay: a RD_LAT-deep shift register of {valid, tag} with synchronous clear. It is reused by the other readout blocks.

Test Plan:
- Defaults; start with BX=3 and nent: port0=2, port5=1, others 0 → rd_addr sequence 0xC0, 0xC1, 0xC0 with rd_en 0x001, 0x001, 0x020. Stream emits tags 0, 0, 5 in consecutive cycles, first word 3 clocks after the first rd_en. done rises on the cycle of the last word.
- All nent=0, start → no rd_en. stream_out stays 0xF00000000000 with stream_valid=0. done=1 three clocks after start.
- All 12 ports nent=10 (120 > TMAX=108) → exactly 108 reads; port 10 stops at addr 7; port 11 is never read. truncated=1, done=1.
- Second start while READ is on port 2 → reads restart with the new BX page. No word tagged with old data appears after the restart plus RD_LAT+1 cycles. done is cleared.
- Port 3 nent=64 (full page) → addresses 0..63 with no wrap or skip; 64 valid words tagged 3.
- reset asserted mid-stream → the next cycle shows the idle word, rd_en=0 and done=0. A subsequent start behaves as from cold reset.
